// File: rtl/aes_mem_responder.sv
// aes_mem_responder: Avalon-MM byte memory that clears itself after reset and serves pipelined reads.
module aes_mem_responder #(
   parameter int DEPTH        = 512,
   parameter int READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [7:0]  writedata,
   output logic        waitrequest,
   output logic [7:0]  readdata,
   output logic        readdatavalid,
   output logic        init_done,
   output logic        err
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {INIT, READY} state_t;
   state_t state;
   logic [AW-1:0] cnt, idx, wa;
   logic [7:0] mem [DEPTH];
   logic [7:0] wd, rd_data;
   logic in_range, rdy, rd_acc, wr_acc, we;
   logic [READ_LATENCY-1:0] v, vin;
   logic [8*READ_LATENCY-1:0] d, din;
   assign idx = address[AW-1:0];
   assign in_range = (address >> AW) == 0;
   assign rdy = state == READY;
   assign waitrequest = !rdy;
   assign rd_acc = rdy & read;
   assign wr_acc = rdy & write & !read & in_range;
   always_comb begin
      we = !rdy | wr_acc;
      wa = rdy ? idx : cnt;
      wd = rdy ? writedata : 8'h00;
      rd_data = in_range ? mem[idx] : 8'h00;
   end
   always_ff @(posedge clk)
      if (we) mem[wa] <= wd;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= INIT;
         cnt <= '0;
         init_done <= 1'b0;
         err <= 1'b0;
      end else if (state == INIT) begin
         cnt <= cnt + 1'b1;
         if (cnt == AW'(DEPTH - 1)) begin
            state <= READY;
            init_done <= 1'b1;
         end
      end else if (((read | write) & !in_range) | (read & write))
         err <= 1'b1;
   // Each stage loads only when a valid read enters it, so the last stage holds readdata between strobes.
   assign vin = READ_LATENCY'({v, rd_acc});
   assign din = (8*READ_LATENCY)'({d, rd_data});
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         v <= '0;
         d <= '0;
      end else begin
         v <= vin;
         for (int k = 0; k < READ_LATENCY; k++)
            if (vin[k]) d[8*k +: 8] <= din[8*k +: 8];
      end
   assign readdatavalid = v[READ_LATENCY-1];
   assign readdata = d[8*READ_LATENCY-1 -: 8];
endmodule

// File: tb/tb_aes_mem_responder.sv
// tb_aes_mem_responder: random and directed checks of aes_mem_responder against a byte-array model.
module tb_aes_mem_responder;
   localparam int DEPTH = 512;
   localparam int RL = 2;
   logic clk = 0;
   logic rst = 1;
   logic [31:0] address = 0;
   logic read = 0, write = 0;
   logic [7:0] writedata = 0;
   logic waitrequest, readdatavalid, init_done, err;
   logic [7:0] readdata;
   int tests = 0, fails = 0, cyc = 0;
   logic [7:0] ref_mem [DEPTH];
   logic [7:0] q_d[$];
   int q_due[$];
   logic [7:0] last_rd = 0;
   logic err_exp = 0;

   aes_mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
      .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
      .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata),
      .readdatavalid(readdatavalid), .init_done(init_done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every read the model accepts is queued with the cycle its strobe is due.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_rdv", readdatavalid, 0);
         last_rd = 0;
      end else if (readdatavalid) begin
         if (q_d.size() == 0) chk("spurious_rdv", readdatavalid, 0);
         else begin
            chk("rdata", readdata, q_d.pop_front());
            chk("rlat", cyc, q_due.pop_front());
         end
         last_rd = readdata;
      end else begin
         chk("hold", readdata, last_rd);
         if (q_due.size() > 0 && q_due[0] <= cyc) begin
            chk("missing_rdv", readdatavalid, 1);
            void'(q_d.pop_front());
            void'(q_due.pop_front());
         end
      end
   end

   task automatic model_reset();
      foreach (ref_mem[i]) ref_mem[i] = 8'h00;
      q_d.delete();
      q_due.delete();
      err_exp = 0;
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (waitrequest === 1'b1 && n < 2000) begin
         step();
         n++;
      end
   endtask

   task automatic do_op(input bit r, input bit w, input logic [31:0] a, input logic [7:0] dat);
      bit ok;
      ok = a < DEPTH;
      chk("waitrequest_ready", waitrequest, 0);
      read = r;
      write = w;
      address = a;
      writedata = dat;
      step();
      if (r) begin
         q_d.push_back(ok ? ref_mem[a] : 8'h00);
         q_due.push_back(cyc + RL - 1);
      end
      if (w && !r && ok) ref_mem[a] = dat;
      if (((r || w) && !ok) || (r && w)) err_exp = 1;
      read = 0;
      write = 0;
      chk("err", err, err_exp);
   endtask

   initial begin
      int n;
      bit r, w;
      logic [31:0] a;
      model_reset();
      step();
      step();
      chk("rst_waitrequest", waitrequest, 1);
      chk("rst_readdata", readdata, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_err", err, 0);
      // Held read during clear must wait, then be served.
      read = 1;
      address = 5;
      rst = 0;
      wait_init(n);
      chk("init_len", n, DEPTH);
      chk("init_done", init_done, 1);
      chk("init_err", err, 0);
      do_op(1, 0, 5, 0);
      for (int i = 0; i < 288; i++) do_op(0, 1, i, 8'(i));
      for (int i = 0; i < 288; i++) do_op(1, 0, i, 0);
      repeat (RL + 1) step();
      chk("burst_err", err, 0);
      do_op(0, 1, 16, 8'hA5);
      do_op(1, 0, 16, 0);
      do_op(1, 1, 3, 8'h77);
      do_op(1, 0, 3, 0);
      do_op(1, 0, 32'h0000_0200, 0);
      do_op(0, 1, 32'h1000_0001, 8'hEE);
      do_op(1, 0, 1, 0);
      repeat (4) step();
      chk("err_sticky", err, 1);
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 1);
         w = r ? ($urandom_range(0, 7) == 0) : $urandom_range(0, 1);
         a = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 15);
         do_op(r, w, a, 8'($urandom));
      end
      repeat (RL + 1) step();
      chk("drain1", q_d.size(), 0);
      // Reset with a read in flight: its strobe must never appear.
      do_op(1, 0, 7, 0);
      do_op(1, 0, 8, 0);
      read = 1;
      address = 9;
      step();
      rst = 1;
      read = 0;
      model_reset();
      step();
      chk("rst2_waitrequest", waitrequest, 1);
      chk("rst2_err", err, 0);
      chk("rst2_init_done", init_done, 0);
      rst = 0;
      repeat (100) step();
      chk("midinit_wait", waitrequest, 1);
      rst = 1;
      step();
      rst = 0;
      wait_init(n);
      chk("reinit_len", n, DEPTH);
      chk("reinit_readdata", readdata, 0);
      for (int i = 0; i < 4; i++) do_op(1, 0, i, 0);
      do_op(1, 0, 16, 0);
      repeat (RL + 2) step();
      chk("drain2", q_d.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
